// File: rtl/cpu_pkg.sv
// Shared types and helpers for the iterative MULT/MULTU and DIV/DIVU units.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } mult_state_t;

    // Magnitude of a default-width operand: negate only when it is signed and negative.
    // The most-negative value maps to 2^(W-1), which still fits as an unsigned magnitude.
    function automatic logic [WIDTH_DEFAULT-1:0] abs_val(
        input logic [WIDTH_DEFAULT-1:0] value,
        input logic                     is_signed
    );
        if (is_signed && value[WIDTH_DEFAULT-1]) begin
            return ~value + WIDTH_DEFAULT'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/twos_negate.sv
// Two's-complement negation of a W-bit value.
// Latency: purely combinational.
// Backpressure: not applicable.
module twos_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_dat,
    output logic [W-1:0] out_dat
);

    assign out_dat = ~in_dat + W'(1);

endmodule

// File: rtl/mult_unit.sv
// Sequential shift-add multiplier producing a 2*WIDTH product into HI/LO.
// Latency: start at edge t, done pulse and new HI/LO after edge t+WIDTH+1.
// Backpressure: start is only accepted in IDLE; starts while busy/finishing are dropped.
module mult_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] counter
);

    mult_state_t      state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   a_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    twos_negate #(.W(WIDTH)) u_neg_a (
        .in_dat  (A),
        .out_dat (a_neg)
    );

    twos_negate #(.W(2*WIDTH)) u_neg_prod (
        .in_dat  (prod),
        .out_dat (prod_neg)
    );

    assign mag_a = (is_signed && A[WIDTH-1]) ? a_neg : A;
    assign mag_b = abs_val(B, is_signed);
    assign prod  = {acc_hi_q, acc_lo_q};
    // One extra bit keeps the carry so the following shift brings it into the top.
    assign sum   = {1'b0, acc_hi_q} + {1'b0, (mplr_q[0] ? mcand_q : '0)};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = mag_a;
                    mplr_d   = mag_b;
                    neg_d    = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_hi_d = '0;
                    acc_lo_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Shift {carry, acc, multiplier} right by one; the consumed LSB drops out.
                {acc_hi_d, acc_lo_d, mplr_d} = {sum, acc_lo_q, mplr_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FINISH;
                end else begin
                    busy_d = 1'b1;
                end
            end
            FINISH: begin
                {hi_d, lo_d} = neg_q ? prod_neg : prod;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears results and abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign HI      = hi_q;
    assign LO      = lo_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign counter = cnt_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed table, hand-written corner sequences
// and back-to-back random operations checked against a plain-arithmetic model.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic [5:0]  counter;

    int errors = 0;
    int checks = 0;

    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[6];

    mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .HI        (HI),
        .LO        (LO),
        .busy      (busy),
        .done      (done),
        .counter   (counter)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference product from the instruction definition: exact integer product mod 2^64.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    // Issue one operation and watch it to completion. With chain set, the task returns in
    // the cycle done is high so the next call starts in that same cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eh, input logic [31:0] el,
                          input bit chain, input bit inject, input string tag);
        int          lat;
        int          busy_cnt;
        int          done_cnt;
        int          hold_bad;
        logic [5:0]  cnt32;
        A = a;
        B = b;
        is_signed = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        lat = -1;
        busy_cnt = 0;
        done_cnt = 0;
        hold_bad = 0;
        cnt32 = '1;
        for (int k = 0; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (k == 32) cnt32 = counter;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end else if (lat < 0 && (HI !== prev_hi || LO !== prev_lo)) begin
                hold_bad++;
            end
            if (done && chain) break;
            if (inject && k == 10) begin
                start = 1'b1;
                A = ~a;
                B = b + 32'd1;
            end
            if (inject && k == 11) start = 1'b0;
            tick();
        end
        chk({tag, " latency"}, 64'(lat), 64'd33);
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
        chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, " hold"}, 64'(hold_bad), 64'd0);
        chk({tag, " counter_at_32"}, 64'(cnt32), 64'd32);
        chk({tag, " HI"}, 64'(HI), 64'(eh));
        chk({tag, " LO"}, 64'(LO), 64'(el));
        prev_hi = eh;
        prev_lo = el;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] rp;
        int          dcnt;

        vecs[0] = '{a: 32'd7,         b: 32'd6,         s: 1'b0, hi: 32'h00000000, lo: 32'h0000002A};
        vecs[1] = '{a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF,  s: 1'b0, hi: 32'hFFFFFFFE, lo: 32'h00000001};
        vecs[2] = '{a: 32'hFFFFFFFE,  b: 32'd3,         s: 1'b1, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFA};
        vecs[3] = '{a: 32'hFFFFFFFE,  b: 32'd3,         s: 1'b0, hi: 32'h00000002, lo: 32'hFFFFFFFA};
        vecs[4] = '{a: 32'h80000000,  b: 32'h80000000,  s: 1'b1, hi: 32'h40000000, lo: 32'h00000000};
        vecs[5] = '{a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF,  s: 1'b1, hi: 32'h00000000, lo: 32'h00000001};

        reset = 1'b0;
        start = 1'b0;
        is_signed = 1'b0;
        A = '0;
        B = '0;
        repeat (3) tick();
        chk("reset HI", 64'(HI), 64'd0);
        chk("reset LO", 64'(LO), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset counter", 64'(counter), 64'd0);

        // Reset and start together: reset wins, nothing starts.
        start = 1'b1;
        A = 32'd5;
        B = 32'd5;
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        chk("reset_vs_start busy", 64'(busy), 64'd0);
        chk("reset_vs_start counter", 64'(counter), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].hi, vecs[i].lo, 1'b0, 1'b0,
                   $sformatf("vec%0d", i));
        end

        // A start arriving mid-run must be dropped; the first result is delivered once.
        rp = ref_mul(32'd12345, 32'd678, 1'b0);
        run_op(32'd12345, 32'd678, 1'b0, rp[63:32], rp[31:0], 1'b0, 1'b1, "start_while_busy");

        // Reset in the middle of a run clears outputs and suppresses done.
        A = 32'd1000;
        B = 32'd1000;
        is_signed = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        reset = 1'b0;
        tick();
        chk("midreset HI", 64'(HI), 64'd0);
        chk("midreset LO", 64'(LO), 64'd0);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset counter", 64'(counter), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        reset = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) dcnt++;
            tick();
        end
        chk("midreset no_activity", 64'(dcnt), 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        rp = ref_mul(32'hDEADBEEF, 32'h00C0FFEE, 1'b1);
        run_op(32'hDEADBEEF, 32'h00C0FFEE, 1'b1, rp[63:32], rp[31:0], 1'b0, 1'b0, "after_reset");

        // Random operations issued back to back, each new start in the cycle done is high.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 5 == 0) ra = 32'h80000000;
            if (i % 7 == 0) rb = 32'd0;
            rp = ref_mul(ra, rb, rs);
            run_op(ra, rb, rs, rp[63:32], rp[31:0], 1'b1, 1'b0, $sformatf("rand%0d", i));
        end
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
